// File: rtl/keypad_scan_ctrl_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM states, scan result codes, row drive patterns.
// Display/shift logic decodes key_code as {row[1:0], col[1:0]}.
package keypad_scan_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_PRESS_DB = 2'd1,
      ST_HELD     = 2'd2,
      ST_REL_DB   = 2'd3
   } kp_state_t;

   typedef enum logic [1:0] {
      RES_NONE   = 2'd0,
      RES_SINGLE = 2'd1,
      RES_MULTI  = 2'd2
   } scan_res_t;

   localparam logic [3:0] H_ROW0 = 4'b1110;
   localparam logic [3:0] H_ROW1 = 4'b1101;
   localparam logic [3:0] H_ROW2 = 4'b1011;
   localparam logic [3:0] H_ROW3 = 4'b0111;

   function automatic logic [3:0] row_drive(input logic [1:0] row);
      logic [3:0] h;
      case (row)
         2'd0:    h = H_ROW0;
         2'd1:    h = H_ROW1;
         2'd2:    h = H_ROW2;
         default: h = H_ROW3;
      endcase
      return h;
   endfunction

endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// Keypad pin and key-event bundle. master = scanner side, slave = keypad/consumer side.
interface keypad_scan_ctrl_if;
   logic [3:0] V;
   logic [3:0] H;
   logic [3:0] key_code;
   logic       key_valid;
   logic       key_held;
   logic       multi_key;

   modport master (input V, output H, key_code, key_valid, key_held, multi_key);
   modport slave  (output V, input H, key_code, key_valid, key_held, multi_key);
endinterface

// File: rtl/keypad_scan_ctrl_row_timer.sv
// Row dwell divider and row sequencer. Strobes o_sample on the last dwell cycle of each row
// and o_scan_end when that row is row 3; H advances on the same edge as the sample.
module keypad_scan_ctrl_row_timer
   import keypad_scan_ctrl_pkg::*;
#(
   parameter int SCAN_DIV = 50000
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic [1:0] o_row,
   output logic       o_sample,
   output logic       o_scan_end,
   output logic [3:0] o_h
);
   localparam int DIV_W = $clog2(SCAN_DIV);

   logic [DIV_W-1:0] r_div;
   logic [1:0]       r_row;
   logic [3:0]       r_h;
   logic             w_sample;

   assign w_sample   = (r_div == DIV_W'(SCAN_DIV - 1));
   assign o_sample   = w_sample;
   assign o_scan_end = w_sample && (r_row == 2'd3);
   assign o_row      = r_row;
   assign o_h        = r_h;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_div <= '0;
         r_row <= 2'd0;
         r_h   <= H_ROW0;
      end else if (w_sample) begin
         r_div <= '0;
         r_row <= r_row + 2'd1;
         r_h   <= row_drive(r_row + 2'd1);
      end else begin
         r_div <= r_div + DIV_W'(1);
      end
   end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scanner: timed row scan, per-scan key accumulation, scan-level debounce,
// one key_valid pulse per accepted press.
module keypad_scan_ctrl
   import keypad_scan_ctrl_pkg::*;
#(
   parameter int SCAN_DIV       = 50000,
   parameter int DEBOUNCE_SCANS = 3
) (
   input  logic               clk,
   input  logic               rst_n,
   keypad_scan_ctrl_if.master kp
);
   localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [CNT_W:0] DEB_LIM = (CNT_W + 1)'(DEBOUNCE_SCANS);

   logic [1:0]       w_row;
   logic             w_sample;
   logic             w_scan_end;
   logic [3:0]       w_h;
   logic [2:0]       w_zeros;
   logic [1:0]       w_col;
   logic [1:0]       w_tot;
   logic [3:0]       w_code;
   scan_res_t        w_res;
   logic [CNT_W:0]   w_cnt_inc;
   logic             w_cnt_hit;

   logic [1:0]       r_acc_n;
   logic [3:0]       r_acc_code;
   kp_state_t        r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [3:0]       r_cand;
   logic [3:0]       r_key_code;
   logic             r_key_valid;
   logic             r_key_held;
   logic             r_multi;

   keypad_scan_ctrl_row_timer #(.SCAN_DIV(SCAN_DIV)) u_row_timer (
      .clk        (clk),
      .rst_n      (rst_n),
      .o_row      (w_row),
      .o_sample   (w_sample),
      .o_scan_end (w_scan_end),
      .o_h        (w_h)
   );

   always_comb begin
      w_zeros = 3'd0;
      w_col   = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (!kp.V[i]) begin
            w_zeros = w_zeros + 3'd1;
            w_col   = i[1:0];
         end
      end
   end

   // r_acc_n counts keys seen so far this scan, saturating at 2 (= multiple)
   always_comb begin
      if (w_zeros == 3'd0)      w_tot = r_acc_n;
      else if (w_zeros == 3'd1) w_tot = (r_acc_n == 2'd0) ? 2'd1 : 2'd2;
      else                      w_tot = 2'd2;
      w_code = (w_zeros == 3'd1 && r_acc_n == 2'd0) ? {w_row, w_col} : r_acc_code;
      case (w_tot)
         2'd0:    w_res = RES_NONE;
         2'd1:    w_res = RES_SINGLE;
         default: w_res = RES_MULTI;
      endcase
   end

   assign w_cnt_inc = {1'b0, r_cnt} + (CNT_W + 1)'(1);
   assign w_cnt_hit = (w_cnt_inc >= DEB_LIM);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc_n    <= 2'd0;
         r_acc_code <= 4'd0;
      end else if (w_scan_end) begin
         r_acc_n    <= 2'd0;
         r_acc_code <= 4'd0;
      end else if (w_sample) begin
         r_acc_n    <= w_tot;
         r_acc_code <= w_code;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_cnt       <= '0;
         r_cand      <= 4'd0;
         r_key_code  <= 4'd0;
         r_key_valid <= 1'b0;
         r_key_held  <= 1'b0;
         r_multi     <= 1'b0;
      end else begin
         r_key_valid <= 1'b0;
         if (w_scan_end) begin
            r_multi <= (w_res == RES_MULTI);
            case (r_state)
               ST_IDLE: begin
                  if (w_res == RES_SINGLE) begin
                     if (DEBOUNCE_SCANS == 1) begin
                        r_state     <= ST_HELD;
                        r_key_code  <= w_code;
                        r_key_valid <= 1'b1;
                        r_key_held  <= 1'b1;
                        r_cnt       <= '0;
                     end else begin
                        r_state <= ST_PRESS_DB;
                        r_cand  <= w_code;
                        r_cnt   <= CNT_W'(1);
                     end
                  end
               end
               ST_PRESS_DB: begin
                  if (w_res == RES_SINGLE && w_code == r_cand) begin
                     if (w_cnt_hit) begin
                        r_state     <= ST_HELD;
                        r_key_code  <= r_cand;
                        r_key_valid <= 1'b1;
                        r_key_held  <= 1'b1;
                        r_cnt       <= '0;
                     end else begin
                        r_cnt <= w_cnt_inc[CNT_W-1:0];
                     end
                  end else if (w_res == RES_SINGLE) begin
                     r_cand <= w_code;
                     r_cnt  <= CNT_W'(1);
                  end else begin
                     r_state <= ST_IDLE;
                     r_cnt   <= '0;
                  end
               end
               ST_HELD: begin
                  // Anything but an empty scan is ignored here: no auto-repeat, no second key
                  if (w_res == RES_NONE) begin
                     if (DEBOUNCE_SCANS == 1) begin
                        r_state    <= ST_IDLE;
                        r_key_held <= 1'b0;
                     end else begin
                        r_state <= ST_REL_DB;
                        r_cnt   <= CNT_W'(1);
                     end
                  end
               end
               ST_REL_DB: begin
                  if (w_res == RES_NONE) begin
                     if (w_cnt_hit) begin
                        r_state    <= ST_IDLE;
                        r_key_held <= 1'b0;
                        r_cnt      <= '0;
                     end else begin
                        r_cnt <= w_cnt_inc[CNT_W-1:0];
                     end
                  end else begin
                     r_state <= ST_HELD;
                     r_cnt   <= '0;
                  end
               end
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   assign kp.H         = w_h;
   assign kp.key_code  = r_key_code;
   assign kp.key_valid = r_key_valid;
   assign kp.key_held  = r_key_held;
   assign kp.multi_key = r_multi;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Scoreboard bench for keypad_scan_ctrl: a keypad model drives V from H, a scan-level reference
// model predicts each scan's outcome, a monitor compares at every scan-end edge.
module tb_keypad_scan_ctrl;
   localparam int SCAN_DIV = 4;
   localparam int DEB      = 3;
   localparam int SCAN_CLK = 4 * SCAN_DIV;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   keypad_scan_ctrl_if kp();

   keypad_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .kp    (kp)
   );

   // Bit (row*4+col) set = that key physically pressed
   logic [15:0] keys = 16'h0000;

   always_comb begin
      kp.V = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (!kp.H[r] && keys[r*4+c]) kp.V[c] = 1'b0;
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {
      int         scan;
      bit         ev;
      logic [3:0] code;
      bit         held;
      bit         multi;
   } exp_t;

   exp_t exp_q[$];

   // Reference model state, per whole scan
   int         scan_no  = 0;
   bit         m_held   = 1'b0;
   int         m_streak = 0;
   int         m_rel    = 0;
   logic [3:0] m_cand   = 4'd0;
   logic [3:0] m_code   = 4'd0;

   task automatic run_scan(input logic [15:0] k);
      exp_t       e;
      int         n;
      logic [3:0] c;
      n = $countones(k);
      c = 4'd0;
      for (int i = 0; i < 16; i++) if (k[i]) c = i[3:0];
      keys = k;
      scan_no++;
      e.ev = 1'b0;
      if (!m_held) begin
         if (n == 1) begin
            m_streak = (m_streak > 0 && c == m_cand) ? m_streak + 1 : 1;
            m_cand   = c;
            if (m_streak == DEB) begin
               e.ev     = 1'b1;
               m_held   = 1'b1;
               m_code   = c;
               m_streak = 0;
               m_rel    = 0;
            end
         end else begin
            m_streak = 0;
         end
      end else begin
         if (n == 0) begin
            m_rel++;
            if (m_rel == DEB) begin
               m_held = 1'b0;
               m_rel  = 0;
            end
         end else begin
            m_rel = 0;
         end
      end
      e.scan  = scan_no;
      e.code  = m_code;
      e.held  = m_held;
      e.multi = (n > 1);
      exp_q.push_back(e);
      repeat (SCAN_CLK) @(negedge clk);
   endtask

   // Monitor
   int         edge_cnt;
   logic [3:0] exp_h;
   exp_t       got;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) edge_cnt <= 0;
      else        edge_cnt <= edge_cnt + 1;
   end

   always @(negedge clk) begin
      if (rst_n && edge_cnt > 0) begin
         exp_h = ~(4'b0001 << ((edge_cnt / SCAN_DIV) % 4));
         check("H_drive", kp.H, exp_h);
         if (edge_cnt % SCAN_CLK == 0) begin
            if (exp_q.size() == 0) begin
               check("scoreboard_depth", 32'(exp_q.size()), 1);
            end else begin
               got = exp_q.pop_front();
               $display("[TB] scan %0d: valid=%0b code=%h held=%0b multi=%0b (exp %0b %h %0b %0b)",
                        got.scan, kp.key_valid, kp.key_code, kp.key_held, kp.multi_key,
                        got.ev, got.code, got.held, got.multi);
               check("scan_index", edge_cnt / SCAN_CLK, got.scan);
               check("key_valid", kp.key_valid, got.ev);
               check("key_code", kp.key_code, got.code);
               check("key_held", kp.key_held, got.held);
               check("multi_key", kp.multi_key, got.multi);
            end
         end else begin
            check("key_valid_off_scan_end", kp.key_valid, 0);
         end
      end
   end

   task automatic check_reset_state(input string tag);
      check({tag, "_H"},         kp.H, 4'b1110);
      check({tag, "_key_code"},  kp.key_code, 0);
      check({tag, "_key_valid"}, kp.key_valid, 0);
      check({tag, "_key_held"},  kp.key_held, 0);
      check({tag, "_multi_key"}, kp.multi_key, 0);
   endtask

   int          rsel;
   int          reps;
   int          a;
   int          b;
   logic [15:0] kr;
   int          keyset[4] = '{6, 9, 0, 15};

   initial begin
      keys = 16'h0040;                          // row1/col2 held from time 0
      repeat (3) @(negedge clk);
      check_reset_state("reset");
      rst_n = 1'b1;

      repeat (13) run_scan(16'h0040);           // accept at scan 3, then 10 held scans
      repeat (3)  run_scan(16'h0000);           // release
      repeat (3)  run_scan(16'h0040);           // re-press
      repeat (3)  run_scan(16'h0000);
      repeat (2)  run_scan(16'h0200);           // short press, rejected
      repeat (2)  run_scan(16'h0000);
      repeat (3)  run_scan(16'h8001);           // two keys in different rows
      repeat (4)  run_scan(16'h8000);           // remaining key accepted, code 1111
      run_scan(16'h0000);                       // release bounce
      repeat (2)  run_scan(16'h8000);
      repeat (3)  run_scan(16'h0000);
      repeat (2)  run_scan(16'h0030);           // two keys in one row

      repeat (40) begin
         rsel = $urandom_range(0, 9);
         if (rsel < 4) begin
            kr = 16'h0000;
         end else if (rsel < 9) begin
            kr = 16'h0001 << keyset[$urandom_range(0, 3)];
         end else begin
            a  = $urandom_range(0, 15);
            b  = (a + 1 + $urandom_range(0, 14)) % 16;
            kr = (16'h0001 << a) | (16'h0001 << b);
         end
         reps = $urandom_range(1, 5);
         repeat (reps) run_scan(kr);
      end

      repeat (3) run_scan(16'h0000);
      repeat (4) run_scan(16'h0020);            // held key 0101
      check("held_before_reset", kp.key_held, 1);
      repeat (7) @(posedge clk);
      #1 rst_n = 1'b0;
      #1 check_reset_state("async_reset");
      exp_q.delete();
      scan_no  = 0;
      m_held   = 1'b0;
      m_streak = 0;
      m_rel    = 0;
      m_code   = 4'd0;
      keys     = 16'h0000;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) run_scan(16'h0000);
      @(posedge clk);
      check("scoreboard_drained", 32'(exp_q.size()), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
